id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage pipeline; captures decoded control bits, operands and register specifiers from ID and presents them to EX, which feeds the EX/MEM control register.
- Integrates load-use hazard detection: bubble insertion plus PC/IF-ID write-enable suppression.
- Integrates branch flush and a downstream memory hold, with a pending-flush latch so a flush arriving during a hold is never lost.

Parameters:
- DATA_W, 32, operand and immediate width.
- REG_ADDR_W, 5, register specifier width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- hold  in  1  downstream memory busy; freeze this register.
- flush  in  1  branch taken, resolved later; squash the ID instruction.
- id_valid  in  1  ID holds a real instruction.
- id_MemRead, id_MemtoReg, id_MemWrite, id_RegWrite, id_ALUSrc, id_RegDst  in  1 each  decoded controls.
- id_ALUOp  in  2  ALU operation class.
- id_uses_rt  in  1  instruction reads rt as a source.
- id_rs_data, id_rt_data, id_imm  in  DATA_W each  operands.
- id_rs, id_rt, id_rd  in  REG_ADDR_W each  specifiers.
- ex_* outputs  out  same widths  registered copies of every id_* input above (ex_valid, ex_MemRead … ex_rd).
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register update enable.
- load_use_stall  out  1  hazard indicator.

Behaviour:
- Async reset:
  - All ex_* outputs 0, including ex_valid.
  - pending_flush = 0.
  - Stall/enable outputs settle to pc_write = 1, ifid_write = 1, load_use_stall = 0.
- Latency: 1 cycle, ID inputs to ex_* outputs.
- Hazard (combinational), all terms true:
  - ex_valid & ex_MemRead;
  - ex_rd != 0;
  - ex_rd == id_rs, or (id_uses_rt & ex_rd == id_rt);
  - id_valid;
  - not effective_flush.
- effective_flush = flush | pending_flush.
- load_use_stall = hazard & ~hold.
- pc_write = ifid_write = ~(load_use_stall | hold).
- Per-edge priority (highest first):
  - 1. hold = 1: all ex_* keep their values. If flush = 1, set pending_flush = 1.
  - 2. effective_flush = 1: load bubble (all control bits and ex_valid = 0; data/specifier fields are don't-care and are zeroed). Clear pending_flush.
  - 3. load_use_stall = 1: load bubble. IF/ID and PC are frozen by their enables, so ID re-presents the same instruction next cycle.
  - 4. Otherwise: load all id_* fields.
- Bubble semantics: a bubble has MemRead = 0, so a load-use stall lasts exactly one cycle.
- id_valid = 0: fields load normally with ex_valid = 0. Control bits are forced to 0 so downstream stages never write.
- Reset mid-hold discards pending_flush.
- Simultaneous flush and hazard: flush wins; no stall is asserted.
- Any number of consecutive hold cycles is allowed. pending_flush stays set until the first non-hold edge.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined: adds 32-bit outputs stall_count and bubble_count.
  - stall_count increments on every edge with load_use_stall = 1.
  - bubble_count increments on every edge a bubble is loaded, whether from flush or stall.
  - Both saturate at all-ones and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg:
  - DATA_W and REG_ADDR_W constants.
  - ALUOp encoding constants.
  - A struct/typedef bundling the control bits: MemRead, MemtoReg, MemWrite, RegWrite, ALUSrc, RegDst, ALUOp. The EX/MEM and MEM/WB registers reuse the memory and write-back subset.
- Sub-module hazard_detect: purely combinational; computes hazard from the ex_* and id_* specifiers. It is reused unchanged if forwarding changes.

Test Plan:
1. Reset then straight-line: load id_RegWrite = 1, id_rd = 5, ALU op for 3 cycles -> ex_* follow ID with 1-cycle latency; pc_write = 1 throughout.
2. Load-use: ex holds lw with ex_rd = 7 and MemRead = 1; ID add with id_rs = 7 -> load_use_stall = 1 and pc_write = ifid_write = 0 for exactly 1 cycle; next ex_* = bubble; the following cycle the add enters EX.
3. No false stall: ex_rd = 0, or ex_rd = id_rt with id_uses_rt = 0 -> no stall.
4. Flush vs. hazard: same setup as scenario 2 plus flush = 1 -> load_use_stall = 0, bubble loaded, pc_write = 1.
5. Flush during hold: hold = 1 for 3 cycles, flush pulsed in cycle 2 -> ex_* frozen throughout the hold; on the first edge after hold drops, a bubble is loaded and pending_flush clears.
6. Async reset asserted mid-hold with pending_flush = 1 -> outputs zero immediately (before the next clock); after release, a normal instruction loads with no spurious bubble.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline widths, ALUOp encodings and control bundles
//
// Purpose: types and constants shared by the pipeline registers.
//   DATA_W, REG_ADDR_W  : default operand and register specifier widths
//   ALUOP_*             : ALU operation class encodings
//   ex_ctrl_t           : controls consumed in EX (ALUSrc, RegDst, ALUOp)
//   mem_ctrl_t          : controls consumed in MEM (MemRead, MemWrite)
//   wb_ctrl_t           : controls consumed in WB (RegWrite, MemtoReg)
//   ctrl_t              : full ID/EX control bundle (ex + mem + wb)
//   gate_ctrl()         : returns the bundle, or all-zero when not valid
package pipe_pkg;

   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_IMM   = 2'b11;

   typedef struct packed {
      logic       ALUSrc;
      logic       RegDst;
      logic [1:0] ALUOp;
   } ex_ctrl_t;

   // MEM and WB subsets are split out so EX/MEM and MEM/WB can carry only
   // the part they still need.
   typedef struct packed {
      logic MemRead;
      logic MemWrite;
   } mem_ctrl_t;

   typedef struct packed {
      logic RegWrite;
      logic MemtoReg;
   } wb_ctrl_t;

   typedef struct packed {
      ex_ctrl_t  ex;
      mem_ctrl_t mem;
      wb_ctrl_t  wb;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

   function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic valid);
      return valid ? c : CTRL_NOP;
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard detection
//
// Purpose: flags an ID instruction that reads the destination of a load
// currently in EX. Pure combinational logic, independent of forwarding.
// Ports:
//   ex_valid_i, ex_mem_read_i : EX holds a real load
//   ex_rd_i                   : destination of the EX instruction
//   id_rs_i, id_rt_i          : source specifiers of the ID instruction
//   id_uses_rt_i              : ID instruction reads rt
//   id_valid_i                : ID holds a real instruction
//   flush_i                   : effective flush; a squashed ID never stalls
//   hazard_o                  : load-use hazard present
module hazard_detect #(
   parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W
) (
   input  logic                  ex_valid_i,
   input  logic                  ex_mem_read_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_i,
   input  logic [REG_ADDR_W-1:0] id_rs_i,
   input  logic [REG_ADDR_W-1:0] id_rt_i,
   input  logic                  id_uses_rt_i,
   input  logic                  id_valid_i,
   input  logic                  flush_i,
   output logic                  hazard_o
);

   logic rs_match;
   logic rt_match;

   assign rs_match = (ex_rd_i == id_rs_i);
   assign rt_match = id_uses_rt_i && (ex_rd_i == id_rt_i);

   // Register 0 is hard-wired, so a load targeting it never creates a dependency.
   assign hazard_o = ex_valid_i && ex_mem_read_i && (ex_rd_i != '0)
                   && (rs_match || rt_match) && id_valid_i && !flush_i;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall, flush and hold
//
// Purpose: registers decoded controls, operands and specifiers from ID for EX,
// inserts bubbles on load-use hazards and branch flushes, freezes on a
// downstream hold and remembers a flush that arrives while held.
// Optional feature macro: ID_EX_PERF_CNT_EN (adds stall_count / bubble_count).
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   hold                  : downstream busy, freeze the register
//   flush                 : squash the instruction in ID
//   id_*                  : decoded ID fields (valid, controls, operands, specifiers)
//   ex_*                  : registered copies of id_* presented to EX
//   pc_write, ifid_write  : PC and IF/ID update enables
//   load_use_stall        : load-use hazard being serviced this cycle
//   stall_count           : (optional) saturating count of stall edges
//   bubble_count          : (optional) saturating count of bubbles loaded
module id_ex_stage #(
   parameter int DATA_W     = pipe_pkg::DATA_W,
   parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  hold,
   input  logic                  flush,
   input  logic                  id_valid,
   input  logic                  id_MemRead,
   input  logic                  id_MemtoReg,
   input  logic                  id_MemWrite,
   input  logic                  id_RegWrite,
   input  logic                  id_ALUSrc,
   input  logic                  id_RegDst,
   input  logic [1:0]            id_ALUOp,
   input  logic                  id_uses_rt,
   input  logic [DATA_W-1:0]     id_rs_data,
   input  logic [DATA_W-1:0]     id_rt_data,
   input  logic [DATA_W-1:0]     id_imm,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   output logic                  ex_valid,
   output logic                  ex_MemRead,
   output logic                  ex_MemtoReg,
   output logic                  ex_MemWrite,
   output logic                  ex_RegWrite,
   output logic                  ex_ALUSrc,
   output logic                  ex_RegDst,
   output logic [1:0]            ex_ALUOp,
   output logic                  ex_uses_rt,
   output logic [DATA_W-1:0]     ex_rs_data,
   output logic [DATA_W-1:0]     ex_rt_data,
   output logic [DATA_W-1:0]     ex_imm,
   output logic [REG_ADDR_W-1:0] ex_rs,
   output logic [REG_ADDR_W-1:0] ex_rt,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  load_use_stall
`ifdef ID_EX_PERF_CNT_EN
   ,
   output logic [31:0]           stall_count,
   output logic [31:0]           bubble_count
`endif
);

   import pipe_pkg::*;

   ctrl_t                 id_ctrl;
   ctrl_t                 ctrl_q,     ctrl_d;
   logic                  valid_q,    valid_d;
   logic                  uses_rt_q,  uses_rt_d;
   logic [DATA_W-1:0]     rs_data_q,  rs_data_d;
   logic [DATA_W-1:0]     rt_data_q,  rt_data_d;
   logic [DATA_W-1:0]     imm_q,      imm_d;
   logic [REG_ADDR_W-1:0] rs_q,       rs_d;
   logic [REG_ADDR_W-1:0] rt_q,       rt_d;
   logic [REG_ADDR_W-1:0] rd_q,       rd_d;
   logic                  pending_flush_q, pending_flush_d;

   logic effective_flush;
   logic hazard;
   logic load_bubble;

   assign id_ctrl = '{ex:  '{ALUSrc: id_ALUSrc, RegDst: id_RegDst, ALUOp: id_ALUOp},
                      mem: '{MemRead: id_MemRead, MemWrite: id_MemWrite},
                      wb:  '{RegWrite: id_RegWrite, MemtoReg: id_MemtoReg}};

   // A flush seen during a hold is replayed on the first free edge.
   assign effective_flush = flush | pending_flush_q;

   hazard_detect #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_hazard_detect (
      .ex_valid_i    (valid_q),
      .ex_mem_read_i (ctrl_q.mem.MemRead),
      .ex_rd_i       (rd_q),
      .id_rs_i       (id_rs),
      .id_rt_i       (id_rt),
      .id_uses_rt_i  (id_uses_rt),
      .id_valid_i    (id_valid),
      .flush_i       (effective_flush),
      .hazard_o      (hazard)
   );

   assign load_use_stall = hazard & ~hold;
   assign pc_write       = ~(load_use_stall | hold);
   assign ifid_write     = ~(load_use_stall | hold);

   // A bubble is loaded only on edges the register is free to change.
   assign load_bubble = ~hold & (effective_flush | load_use_stall);

   always_comb begin
      ctrl_d          = ctrl_q;
      valid_d         = valid_q;
      uses_rt_d       = uses_rt_q;
      rs_data_d       = rs_data_q;
      rt_data_d       = rt_data_q;
      imm_d           = imm_q;
      rs_d            = rs_q;
      rt_d            = rt_q;
      rd_d            = rd_q;
      pending_flush_d = pending_flush_q;

      if (hold) begin
         if (flush) begin
            pending_flush_d = 1'b1;
         end
      end else if (load_bubble) begin
         ctrl_d          = CTRL_NOP;
         valid_d         = 1'b0;
         uses_rt_d       = 1'b0;
         rs_data_d       = '0;
         rt_data_d       = '0;
         imm_d           = '0;
         rs_d            = '0;
         rt_d            = '0;
         rd_d            = '0;
         pending_flush_d = 1'b0;
      end else begin
         // Invalid ID slots still carry their fields but can never write.
         ctrl_d    = gate_ctrl(id_ctrl, id_valid);
         valid_d   = id_valid;
         uses_rt_d = id_uses_rt;
         rs_data_d = id_rs_data;
         rt_data_d = id_rt_data;
         imm_d     = id_imm;
         rs_d      = id_rs;
         rt_d      = id_rt;
         rd_d      = id_rd;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q          <= CTRL_NOP;
         valid_q         <= 1'b0;
         uses_rt_q       <= 1'b0;
         rs_data_q       <= '0;
         rt_data_q       <= '0;
         imm_q           <= '0;
         rs_q            <= '0;
         rt_q            <= '0;
         rd_q            <= '0;
         pending_flush_q <= 1'b0;
      end else begin
         ctrl_q          <= ctrl_d;
         valid_q         <= valid_d;
         uses_rt_q       <= uses_rt_d;
         rs_data_q       <= rs_data_d;
         rt_data_q       <= rt_data_d;
         imm_q           <= imm_d;
         rs_q            <= rs_d;
         rt_q            <= rt_d;
         rd_q            <= rd_d;
         pending_flush_q <= pending_flush_d;
      end
   end

   assign ex_valid    = valid_q;
   assign ex_MemRead  = ctrl_q.mem.MemRead;
   assign ex_MemWrite = ctrl_q.mem.MemWrite;
   assign ex_MemtoReg = ctrl_q.wb.MemtoReg;
   assign ex_RegWrite = ctrl_q.wb.RegWrite;
   assign ex_ALUSrc   = ctrl_q.ex.ALUSrc;
   assign ex_RegDst   = ctrl_q.ex.RegDst;
   assign ex_ALUOp    = ctrl_q.ex.ALUOp;
   assign ex_uses_rt  = uses_rt_q;
   assign ex_rs_data  = rs_data_q;
   assign ex_rt_data  = rt_data_q;
   assign ex_imm      = imm_q;
   assign ex_rs       = rs_q;
   assign ex_rt       = rt_q;
   assign ex_rd       = rd_q;

`ifdef ID_EX_PERF_CNT_EN
   logic [31:0] stall_cnt_q,  stall_cnt_d;
   logic [31:0] bubble_cnt_q, bubble_cnt_d;

   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (load_use_stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (load_bubble && (bubble_cnt_q != '1)) begin
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign stall_count  = stall_cnt_q;
   assign bubble_count = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

   typedef struct packed {
      logic        valid;
      logic        MemRead;
      logic        MemtoReg;
      logic        MemWrite;
      logic        RegWrite;
      logic        ALUSrc;
      logic        RegDst;
      logic [1:0]  ALUOp;
      logic        uses_rt;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } rec_t;

   localparam int K_LOAD   = 0;
   localparam int K_BUBBLE = 1;
   localparam int K_KEEP   = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic hold = 1'b0;
   logic flush = 1'b0;
   rec_t drv = '0;
   rec_t obs;

   logic        ex_valid, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_RegWrite;
   logic        ex_ALUSrc, ex_RegDst, ex_uses_rt;
   logic [1:0]  ex_ALUOp;
   logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic        pc_write, ifid_write, load_use_stall;
`ifdef ID_EX_PERF_CNT_EN
   logic [31:0] stall_count, bubble_count;
`endif

   int   vectors = 0;
   int   miscompares = 0;
   int   exp_stalls = 0;
   int   exp_bubbles = 0;
   rec_t exp_q[$];
   rec_t last_exp = '0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk            (clk),
      .rst            (rst),
      .hold           (hold),
      .flush          (flush),
      .id_valid       (drv.valid),
      .id_MemRead     (drv.MemRead),
      .id_MemtoReg    (drv.MemtoReg),
      .id_MemWrite    (drv.MemWrite),
      .id_RegWrite    (drv.RegWrite),
      .id_ALUSrc      (drv.ALUSrc),
      .id_RegDst      (drv.RegDst),
      .id_ALUOp       (drv.ALUOp),
      .id_uses_rt     (drv.uses_rt),
      .id_rs_data     (drv.rs_data),
      .id_rt_data     (drv.rt_data),
      .id_imm         (drv.imm),
      .id_rs          (drv.rs),
      .id_rt          (drv.rt),
      .id_rd          (drv.rd),
      .ex_valid       (ex_valid),
      .ex_MemRead     (ex_MemRead),
      .ex_MemtoReg    (ex_MemtoReg),
      .ex_MemWrite    (ex_MemWrite),
      .ex_RegWrite    (ex_RegWrite),
      .ex_ALUSrc      (ex_ALUSrc),
      .ex_RegDst      (ex_RegDst),
      .ex_ALUOp       (ex_ALUOp),
      .ex_uses_rt     (ex_uses_rt),
      .ex_rs_data     (ex_rs_data),
      .ex_rt_data     (ex_rt_data),
      .ex_imm         (ex_imm),
      .ex_rs          (ex_rs),
      .ex_rt          (ex_rt),
      .ex_rd          (ex_rd),
      .pc_write       (pc_write),
      .ifid_write     (ifid_write),
      .load_use_stall (load_use_stall)
`ifdef ID_EX_PERF_CNT_EN
      ,
      .stall_count    (stall_count),
      .bubble_count   (bubble_count)
`endif
   );

   assign obs = {ex_valid, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_RegWrite,
                 ex_ALUSrc, ex_RegDst, ex_ALUOp, ex_uses_rt, ex_rs_data,
                 ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd};

   function automatic rec_t instr(input logic v, input logic mr, input logic mtr,
                                  input logic mw, input logic rw, input logic src,
                                  input logic dst, input logic [1:0] op, input logic ur,
                                  input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic [31:0] base);
      rec_t r;
      r = '{valid: v, MemRead: mr, MemtoReg: mtr, MemWrite: mw, RegWrite: rw,
            ALUSrc: src, RegDst: dst, ALUOp: op, uses_rt: ur, rs_data: base,
            rt_data: ~base, imm: base ^ 32'h0000_5a5a, rs: rs, rt: rt, rd: rd};
      return r;
   endfunction

   // What EX should show after a normal load of r.
   function automatic rec_t loaded(input rec_t r);
      rec_t e;
      e = r;
      if (!r.valid) begin
         e.MemRead  = 1'b0;
         e.MemtoReg = 1'b0;
         e.MemWrite = 1'b0;
         e.RegWrite = 1'b0;
         e.ALUSrc   = 1'b0;
         e.RegDst   = 1'b0;
         e.ALUOp    = 2'b00;
      end
      return e;
   endfunction

   task automatic check_comb(input logic exp_stall, input logic exp_en, input string tag);
      vectors += 3;
      assert (load_use_stall === exp_stall) else begin
         miscompares++;
         $error("FAIL %s.stall observed=%b expected=%b", tag, load_use_stall, exp_stall);
      end
      assert (pc_write === exp_en) else begin
         miscompares++;
         $error("FAIL %s.pc_write observed=%b expected=%b", tag, pc_write, exp_en);
      end
      assert (ifid_write === exp_en) else begin
         miscompares++;
         $error("FAIL %s.ifid_write observed=%b expected=%b", tag, ifid_write, exp_en);
      end
   endtask

   task automatic check_ex(input rec_t e, input string tag);
      vectors++;
      assert (obs === e) else begin
         miscompares++;
         $error("FAIL %s.ex observed=%h expected=%h", tag, obs, e);
      end
   endtask

   // One clock: drive ID + controls, check the combinational enables, push
   // the expected EX contents, then pop and compare after the edge.
   task automatic do_cycle(input rec_t in, input logic h_in, input logic f_in,
                           input int kind, input logic exp_stall, input string tag);
      rec_t e;
      @(negedge clk);
      drv   = in;
      hold  = h_in;
      flush = f_in;
      #1;
      check_comb(exp_stall, ~(exp_stall | h_in), tag);
      case (kind)
         K_LOAD:   e = loaded(in);
         K_BUBBLE: e = '0;
         default:  e = last_exp;
      endcase
      if (kind == K_BUBBLE) exp_bubbles++;
      if (exp_stall) exp_stalls++;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_ex(e, tag);
      last_exp = e;
   endtask

   rec_t add1, add2, add3, lw7, add_rs7, lw0, add_rs0, add_rt7, nv_rs7, x_ins, y_ins, z_ins;

   initial begin
      add1    = instr(1, 0, 0, 0, 1, 0, 1, 2'b10, 1, 5'd1, 5'd2, 5'd5, 32'h1111_0001);
      add2    = instr(1, 0, 0, 0, 1, 0, 1, 2'b10, 1, 5'd3, 5'd4, 5'd5, 32'h2222_0002);
      add3    = instr(1, 0, 0, 0, 1, 1, 0, 2'b11, 0, 5'd6, 5'd8, 5'd5, 32'h3333_0003);
      lw7     = instr(1, 1, 1, 0, 1, 1, 0, 2'b00, 0, 5'd1, 5'd7, 5'd7, 32'h4444_0004);
      add_rs7 = instr(1, 0, 0, 0, 1, 0, 1, 2'b10, 1, 5'd7, 5'd3, 5'd9, 32'h5555_0005);
      lw0     = instr(1, 1, 1, 0, 1, 1, 0, 2'b00, 0, 5'd1, 5'd0, 5'd0, 32'h6666_0006);
      add_rs0 = instr(1, 0, 0, 0, 1, 0, 1, 2'b10, 1, 5'd0, 5'd0, 5'd10, 32'h7777_0007);
      add_rt7 = instr(1, 0, 0, 1, 0, 1, 0, 2'b00, 0, 5'd2, 5'd7, 5'd11, 32'h8888_0008);
      nv_rs7  = instr(0, 1, 0, 1, 1, 1, 1, 2'b01, 1, 5'd7, 5'd7, 5'd12, 32'h9999_0009);
      x_ins   = instr(1, 0, 0, 0, 1, 0, 1, 2'b01, 1, 5'd13, 5'd14, 5'd15, 32'hAAAA_000A);
      y_ins   = instr(1, 0, 0, 0, 1, 0, 1, 2'b10, 1, 5'd16, 5'd17, 5'd18, 32'hBBBB_000B);
      z_ins   = instr(1, 0, 0, 0, 1, 1, 0, 2'b11, 0, 5'd19, 5'd20, 5'd21, 32'hCCCC_000C);

      // Reset state.
      #1;
      check_ex('0, "reset");
      check_comb(1'b0, 1'b1, "reset");
      @(negedge clk);
      rst = 1'b0;

      // 1: straight-line flow, 1-cycle latency.
      do_cycle(add1, 0, 0, K_LOAD, 0, "s1.a");
      do_cycle(add2, 0, 0, K_LOAD, 0, "s1.b");
      do_cycle(add3, 0, 0, K_LOAD, 0, "s1.c");

      // 2: load-use stalls exactly one cycle, then the add enters EX.
      do_cycle(lw7,     0, 0, K_LOAD,   0, "s2.lw");
      do_cycle(add_rs7, 0, 0, K_BUBBLE, 1, "s2.stall");
      do_cycle(add_rs7, 0, 0, K_LOAD,   0, "s2.retry");
      do_cycle(add1,    0, 0, K_LOAD,   0, "s2.next");

      // 3: no false stalls (rd 0, rt unused, invalid ID).
      do_cycle(lw0,     0, 0, K_LOAD, 0, "s3.lw0");
      do_cycle(add_rs0, 0, 0, K_LOAD, 0, "s3.rd0");
      do_cycle(lw7,     0, 0, K_LOAD, 0, "s3.lw7");
      do_cycle(add_rt7, 0, 0, K_LOAD, 0, "s3.rt_unused");
      do_cycle(lw7,     0, 0, K_LOAD, 0, "s3.lw7b");
      do_cycle(nv_rs7,  0, 0, K_LOAD, 0, "s3.invalid");

      // 4: flush beats a simultaneous hazard.
      do_cycle(lw7,     0, 0, K_LOAD,   0, "s4.lw");
      do_cycle(add_rs7, 0, 1, K_BUBBLE, 0, "s4.flush");
      do_cycle(add2,    0, 0, K_LOAD,   0, "s4.after");

      // 5: flush during a 3-cycle hold is replayed after the hold.
      do_cycle(x_ins, 0, 0, K_LOAD,   0, "s5.x");
      do_cycle(y_ins, 1, 0, K_KEEP,   0, "s5.hold1");
      do_cycle(y_ins, 1, 1, K_KEEP,   0, "s5.hold2");
      do_cycle(y_ins, 1, 0, K_KEEP,   0, "s5.hold3");
      do_cycle(y_ins, 0, 0, K_BUBBLE, 0, "s5.replay");
      do_cycle(y_ins, 0, 0, K_LOAD,   0, "s5.cleared");

      // 6: async reset mid-hold drops the pending flush.
      do_cycle(x_ins, 0, 0, K_LOAD, 0, "s6.x");
      do_cycle(y_ins, 1, 1, K_KEEP, 0, "s6.holdflush");
      @(negedge clk);
      hold  = 1'b1;
      flush = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_ex('0, "s6.async");
      last_exp = '0;
      @(negedge clk);
      hold = 1'b0;
      rst  = 1'b0;
      #1;
      check_comb(1'b0, 1'b1, "s6.release");
      do_cycle(z_ins, 0, 0, K_LOAD, 0, "s6.load");

`ifdef ID_EX_PERF_CNT_EN
      // Counters restart at reset: only the post-reset cycle counts, which has no events.
      vectors += 2;
      assert (stall_count === 32'd0) else begin
         miscompares++;
         $error("FAIL perf.stall observed=%0d expected=%0d", stall_count, 0);
      end
      assert (bubble_count === 32'd0) else begin
         miscompares++;
         $error("FAIL perf.bubble observed=%0d expected=%0d", bubble_count, 0);
      end
`endif

      vectors++;
      assert (exp_q.size() == 0) else begin
         miscompares++;
         $error("FAIL scoreboard.drain observed=%0d expected=%0d", exp_q.size(), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
